// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral register bus: opcodes, PIA register
// map, POLL status codes and the bus-master state encoding.
package periph_bus_pkg;

    // Command opcodes carried in byte0[7:6]
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // PIA register addresses
    localparam logic [6:0] SWCHA  = 7'h00;
    localparam logic [6:0] SWACNT = 7'h01;
    localparam logic [6:0] SWCHB  = 7'h02;
    localparam logic [6:0] SWBCNT = 7'h03;
    localparam logic [6:0] INTIM  = 7'h04;
    localparam logic [6:0] INSTAT = 7'h05;
    localparam logic [6:0] TIM1T  = 7'h14;
    localparam logic [6:0] TIM8T  = 7'h15;
    localparam logic [6:0] TIM64T = 7'h16;
    localparam logic [6:0] T1024T = 7'h17;

    // POLL status byte
    localparam logic [7:0] ST_MATCH   = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_MASK,
        S_MATCH,
        S_ISSUE,
        S_CAPTURE,
        S_RSP0,
        S_RSP1
    } pbm_state_t;

    // States in which a command byte may be accepted
    function automatic logic takes_cmd(input pbm_state_t s);
        return (s == S_IDLE) || (s == S_ADDR) || (s == S_WDATA) ||
               (s == S_MASK) || (s == S_MATCH);
    endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Byte-command initiator for the peripheral register bus.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for opcode byte; reserved opcode is dropped here
// S_ADDR    | waiting for address byte
// S_WDATA   | WRITE: waiting for write-data byte
// S_MASK    | POLL: waiting for mask byte
// S_MATCH   | POLL: waiting for match byte
// S_ISSUE   | bus strobe cycle
// S_CAPTURE | cycle after a read strobe; dat_i registered, poll count++
// S_RSP0    | first response byte (READ data or POLL status)
// S_RSP1    | POLL only: last data read
module periph_bus_master #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [6:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    output logic       busy_o
);

    import periph_bus_pkg::*;

    localparam logic [15:0] W_POLL_MAX = 16'(POLL_MAX);

    pbm_state_t r_state;
    pbm_state_t w_state_nxt;

    // Command shadow registers; r_wdat holds write data or the POLL mask
    logic [1:0]  r_op;
    logic [1:0]  w_op_nxt;
    logic [6:0]  r_adr;
    logic [6:0]  w_adr_nxt;
    logic [7:0]  r_wdat;
    logic [7:0]  w_wdat_nxt;
    logic [7:0]  r_match;
    logic [7:0]  w_match_nxt;

    logic [7:0]  r_rdata;
    logic [7:0]  r_status;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_inc;
    logic        w_hit;
    logic        w_ready;
    logic        w_accept;

    logic        r_stb;
    logic        r_we;
    logic [6:0]  r_bus_adr;
    logic [7:0]  r_bus_dat;

    assign w_ready   = takes_cmd(r_state);
    assign w_accept  = cmd_valid_i & w_ready;
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_hit     = ((dat_i & r_wdat) == r_match);

    // Next-state and next shadow-register values
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_adr_nxt   = r_adr;
        w_wdat_nxt  = r_wdat;
        w_match_nxt = r_match;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = cmd_data_i[7:6];
                    w_state_nxt = (cmd_data_i[7:6] == OP_RSVD) ? S_IDLE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_adr_nxt = cmd_data_i[6:0];
                    case (r_op)
                        OP_WRITE: w_state_nxt = S_WDATA;
                        OP_POLL:  w_state_nxt = S_MASK;
                        default:  w_state_nxt = S_ISSUE;
                    endcase
                end
            end
            S_WDATA: begin
                if (w_accept) begin
                    w_wdat_nxt  = cmd_data_i;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_MASK: begin
                if (w_accept) begin
                    w_wdat_nxt  = cmd_data_i;
                    w_state_nxt = S_MATCH;
                end
            end
            S_MATCH: begin
                if (w_accept) begin
                    w_match_nxt = cmd_data_i;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = (r_op == OP_WRITE) ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_op != OP_POLL) begin
                    w_state_nxt = S_RSP0;
                end else if (w_hit || (w_cnt_inc == W_POLL_MAX)) begin
                    w_state_nxt = S_RSP0;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_RSP0: begin
                if (rsp_ready_i) begin
                    w_state_nxt = (r_op == OP_POLL) ? S_RSP1 : S_IDLE;
                end
            end
            S_RSP1: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and command shadow registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_op    <= OP_READ;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_match <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_adr   <= w_adr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_match <= w_match_nxt;
        end
    end

    // Read capture, poll counter and POLL status; match wins over timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_status <= ST_MATCH;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_rdata  <= dat_i;
            r_cnt    <= w_cnt_inc;
            r_status <= w_hit ? ST_MATCH : ST_TIMEOUT;
        end
    end

    // Registered bus outputs, loaded from the next shadow values so the
    // strobe follows the last command byte by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_bus_adr <= '0;
            r_bus_dat <= '0;
        end else begin
            r_stb <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_ISSUE) begin
                r_we      <= (w_op_nxt == OP_WRITE);
                r_bus_adr <= w_adr_nxt;
                if (w_op_nxt == OP_WRITE) begin
                    r_bus_dat <= w_wdat_nxt;
                end
            end
        end
    end

    // Response byte mux; zero whenever no response is pending
    always_comb begin
        rsp_data_o = '0;
        case (r_state)
            S_RSP0:  rsp_data_o = (r_op == OP_POLL) ? r_status : r_rdata;
            S_RSP1:  rsp_data_o = r_rdata;
            default: rsp_data_o = '0;
        endcase
    end

    // Strobe and ready are masked by reset so neither can assert during it
    assign stb_o       = r_stb & ~rst_i;
    assign cmd_ready_o = w_ready & ~rst_i;
    assign we_o        = r_we;
    assign adr_o       = r_bus_adr;
    assign dat_o       = r_bus_dat;
    assign rsp_valid_o = (r_state == S_RSP0) || (r_state == S_RSP1);
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: a small behavioural PIA responder, a command
// byte source and a response sink fed from an expected-byte queue.
module tb_periph_bus_master;

    import periph_bus_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i = 8'h00;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b1;
    logic [7:0] rsp_data_o;
    logic       stb_o;
    logic       we_o;
    logic [6:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       busy_o;

    periph_bus_master #(.POLL_MAX(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Cycle counter for latency measurement
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural PIA: register file, TIM1T down-counter with underflow flag
    logic [7:0] mem [0:127];
    logic [7:0] intim;
    logic       tim1;
    logic       uflow;

    function automatic logic [7:0] rd_val(input logic [6:0] a);
        if (a == INTIM) return intim;
        if (a == INSTAT) return uflow ? 8'hC0 : 8'h00;
        return mem[a];
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[SWCHA] <= 8'hFF;
            intim <= 8'h00;
            tim1  <= 1'b0;
            uflow <= 1'b0;
            dat_i <= 8'h00;
        end else begin
            if (tim1 && intim != 8'h00) begin
                intim <= intim - 8'd1;
                if (intim == 8'd1) uflow <= 1'b1;
            end
            if (stb_o && we_o) begin
                mem[adr_o] <= dat_o;
                if (adr_o >= TIM1T && adr_o <= T1024T) begin
                    intim <= dat_o;
                    tim1  <= (adr_o == TIM1T);
                    uflow <= 1'b0;
                end
            end
            if (stb_o && !we_o) dat_i <= rd_val(adr_o);
        end
    end

    // Strobe / response monitor
    int         n_stb = 0;
    int         stb_cyc = 0;
    int         rsp_cyc = 0;
    int         last_acc = 0;
    logic       last_we = 1'b0;
    logic [6:0] last_adr = 7'h00;
    logic [7:0] last_dat = 8'h00;
    logic       prev_stb = 1'b0;
    logic       prev_rv = 1'b0;

    always @(negedge clk_i) begin
        if (stb_o) begin
            check_val("stb_single_cycle", {31'b0, prev_stb}, 32'd0);
            n_stb++;
            stb_cyc  = cyc;
            last_we  = we_o;
            last_adr = adr_o;
            last_dat = dat_o;
        end
        if (rsp_valid_o && !prev_rv) rsp_cyc = cyc;
        prev_stb = stb_o;
        prev_rv  = rsp_valid_o;
    end

    // Response sink: each accepted byte is compared with the queue head
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_expected", 32'd0, 32'd1);
            end else begin
                check_val("rsp_data", {24'b0, rsp_data_o}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    // Called and returns at posedge+1
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = b;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_val("cmd_accept", {31'b0, cmd_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        last_acc    = cyc - 1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check_val("drain_done", {31'b0, (busy_o || exp_q.size() != 0)}, 32'd0);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        logic [7:0] d;

        // Reset values
        repeat (3) @(negedge clk_i);
        check_val("rst_stb", {31'b0, stb_o}, 32'd0);
        check_val("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_val("rst_busy", {31'b0, busy_o}, 32'd0);
        check_val("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        check_val("rst_rsp_data", {24'b0, rsp_data_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // WRITE TIM64T = 0x10, then read INTIM back
        s0 = n_stb;
        send_byte(8'h40); send_byte(8'h16); send_byte(8'h10);
        wait_drain();
        check_val("wr_nstb", 32'(n_stb - s0), 32'd1);
        check_val("wr_we", {31'b0, last_we}, 32'd1);
        check_val("wr_adr", {25'b0, last_adr}, 32'h16);
        check_val("wr_dat", {24'b0, last_dat}, 32'h10);
        check_val("wr_lat", 32'(stb_cyc - last_acc), 32'd1);
        send_byte(8'h00); send_byte(8'h04); exp_q.push_back(8'h10);
        wait_drain();

        // READ SWCHA
        s0 = n_stb;
        send_byte(8'h00); send_byte(8'h00); exp_q.push_back(8'hFF);
        wait_drain();
        check_val("rd_nstb", 32'(n_stb - s0), 32'd1);
        check_val("rd_we", {31'b0, last_we}, 32'd0);
        check_val("rd_adr", {25'b0, last_adr}, 32'h00);
        check_val("rd_lat_stb", 32'(stb_cyc - last_acc), 32'd1);
        check_val("rd_lat_rsp", 32'(rsp_cyc - stb_cyc), 32'd2);

        // POLL on INSTAT underflow after TIM1T = 3
        send_byte(8'h40); send_byte(8'h14); send_byte(8'h03);
        s0 = n_stb;
        send_byte(8'h80); send_byte(8'h05); send_byte(8'h80); send_byte(8'h80);
        exp_q.push_back(ST_MATCH); exp_q.push_back(8'hC0);
        wait_drain();
        check_val("pu_adr", {25'b0, last_adr}, 32'h05);
        check_val("pu_nstb_ok", {31'b0, (n_stb - s0 >= 1 && n_stb - s0 <= 4)}, 32'd1);

        // POLL timeout against SWCHB bit0 = 0
        s0 = n_stb;
        send_byte(8'h80); send_byte(8'h02); send_byte(8'h01); send_byte(8'h01);
        exp_q.push_back(ST_TIMEOUT); exp_q.push_back(8'h00);
        wait_drain();
        check_val("pt_nstb", 32'(n_stb - s0), 32'd4);
        check_val("pt_adr", {25'b0, last_adr}, 32'h02);

        // Write/read-back of SWBCNT with random data
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            send_byte(8'h40); send_byte(8'h03); send_byte(d);
            wait_drain();
            send_byte(8'h00); send_byte(8'h03); exp_q.push_back(d);
            wait_drain();
        end

        // Backpressure on a READ response
        rsp_ready_i = 1'b0;
        s0 = n_stb;
        send_byte(8'h00); send_byte(8'h00); exp_q.push_back(8'hFF);
        n = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_val("bp_valid", {31'b0, rsp_valid_o}, 32'd1);
        s0 = n_stb;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            check_val("bp_hold_valid", {31'b0, rsp_valid_o}, 32'd1);
            check_val("bp_hold_data", {24'b0, rsp_data_o}, 32'hFF);
            check_val("bp_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
            check_val("bp_stb", {31'b0, stb_o}, 32'd0);
        end
        check_val("bp_nstb", 32'(n_stb - s0), 32'd0);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        wait_drain();

        // Reset in CAPTURE of a POLL drops the command and its response
        send_byte(8'h80); send_byte(8'h02); send_byte(8'h01); send_byte(8'h01);
        n = 0;
        @(negedge clk_i);
        while (!stb_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_val("mr_stb_seen", {31'b0, stb_o}, 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check_val("mr_stb_in_rst", {31'b0, stb_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("mr_stb", {31'b0, stb_o}, 32'd0);
        check_val("mr_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_val("mr_busy", {31'b0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        send_byte(8'h00); send_byte(8'h00); exp_q.push_back(8'hFF);
        wait_drain();

        // Reserved opcode is consumed alone; the next READ parses normally
        send_byte(8'h40); send_byte(8'h01); send_byte(8'h5A);
        wait_drain();
        s0 = n_stb;
        send_byte(8'hC0);
        @(negedge clk_i);
        check_val("rsv_busy", {31'b0, busy_o}, 32'd0);
        check_val("rsv_stb", {31'b0, stb_o}, 32'd0);
        check_val("rsv_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        send_byte(8'h00); send_byte(8'h01); exp_q.push_back(8'h5A);
        wait_drain();
        check_val("rsv_nstb", 32'(n_stb - s0), 32'd1);
        check_val("rsv_adr", {25'b0, last_adr}, 32'h01);

        repeat (5) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
